aes_inv_cipher_core: RTL and testbench

//  Iterative AES inverse cipher (FIPS-197 InvCipher): one round per clock.

---
 rtl/aes_pkg.sv | 54 +++++
 rtl/aes_inv_sbox.sv | 15 +
 rtl/aes_inv_cipher_core.sv | 144 ++++++++++++++
 tb/tb_aes_inv_cipher_core.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, GF(2^8) helpers, inverse S-box and state encoding
//
// Purpose : common definitions used by the AES cipher datapaths.
// Contents: NB (state columns), aes_state_e (FSM encoding), xtime/gf_mul,
//           inv_sbox lookup, byte_at(r,c) bit index of a state byte.
package aes_pkg;

  localparam int NB = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } aes_state_e;

  // Inverse S-box, row-major: entry for byte b sits at [2047-8*b -: 8].
  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX_TBL[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // MSB position of byte (r,c) in a column-major 128-bit state.
  function automatic int byte_at(input int r, input int c);
    return 127 - 8 * (4 * c + r);
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// rtl/aes_inv_sbox.sv - combinational AES inverse S-box
//
// Purpose: one byte through the inverse S-box.
// Ports  : in_byte  - input byte
//          out_byte - InvSubBytes(in_byte)
module aes_inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  assign out_byte = inv_sbox(in_byte);

endmodule

// File: rtl/aes_inv_cipher_core.sv
// rtl/aes_inv_cipher_core.sv - iterative AES inverse cipher, one round per clock
//
// Purpose: decrypts one 128-bit block in NR cycles using round keys fetched
//          by index from an external combinational key store.
// Ports  : clk, rst (async, active high)
//          in_valid/in_ready/in_data     - ciphertext input handshake
//          rk_idx/rk_data                - round-key request and returned key
//          out_valid/out_ready/out_data  - plaintext output handshake
//          busy                          - block in flight (ROUND, FINAL, DONE)
module aes_inv_cipher_core
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
    $error("aes_inv_cipher_core: NR must be 10, 12 or 14");
  end

  localparam logic [3:0] NR_L  = 4'(NR);
  localparam logic [3:0] NR_M1 = 4'(NR - 1);

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[byte_at(r, c) -: 8] = s[byte_at(r, (c + NB - r) % NB) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < NB; c++) begin
      a0 = s[byte_at(0, c) -: 8];
      a1 = s[byte_at(1, c) -: 8];
      a2 = s[byte_at(2, c) -: 8];
      a3 = s[byte_at(3, c) -: 8];
      o[byte_at(0, c) -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[byte_at(1, c) -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[byte_at(2, c) -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[byte_at(3, c) -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  aes_state_e   fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         out_valid_q, out_valid_d;
  logic [127:0] out_data_q, out_data_d;

  // Shared by ROUND and FINAL: InvSubBytes(InvShiftRows(state)) ^ round key.
  logic [127:0] shifted;
  logic [127:0] subbed;
  logic [127:0] keyed;

  assign shifted = inv_shift_rows(state_q);

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_inv_sbox u_inv_sbox (
      .in_byte  (shifted[8*i +: 8]),
      .out_byte (subbed[8*i +: 8])
    );
  end

  assign keyed = subbed ^ rk_data;

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    rnd_d       = rnd_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    rk_idx      = NR_L;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          state_d = in_data ^ rk_data;
          rnd_d   = NR_M1;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        rk_idx  = rnd_q;
        state_d = inv_mix_columns(keyed);
        rnd_d   = rnd_q - 4'd1;
        if (rnd_q == 4'd1) fsm_d = FINAL;
      end
      FINAL: begin
        rk_idx      = 4'd0;
        out_data_d  = keyed;
        out_valid_d = 1'b1;
        fsm_d       = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          fsm_d       = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      rnd_q       <= NR_M1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Held low during reset so nothing is accepted while the core is being cleared.
  assign in_ready  = (fsm_q == IDLE) && !rst;
  assign busy      = (fsm_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_aes_inv_cipher_core.sv
// tb/tb_aes_inv_cipher_core.sv - directed self-checking bench for aes_inv_cipher_core
module tb_aes_inv_cipher_core;

  logic         clk = 1'b0;
  logic         rst = 1'b1;

  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_data;
  logic         busy;

  logic         in_valid14 = 1'b0;
  logic         in_ready14;
  logic [127:0] in_data14 = '0;
  logic [3:0]   rk_idx14;
  logic [127:0] rk_data14;
  logic         out_valid14;
  logic         out_ready14 = 1'b1;
  logic [127:0] out_data14;
  logic         busy14;

  logic [127:0] ks10 [0:15];
  logic [127:0] ks14 [0:15];
  logic [31:0]  w [0:63];
  logic [7:0]   sbox_t [0:255];

  int checks   = 0;
  int failures = 0;

  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] K1  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [255:0] K2  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] CT3 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] K3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  always #5 clk = ~clk;

  assign rk_data   = ks10[rk_idx];
  assign rk_data14 = ks14[rk_idx14];

  aes_inv_cipher_core #(.NR(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rk_idx    (rk_idx),
    .rk_data   (rk_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  aes_inv_cipher_core #(.NR(14)) dut14 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid14),
    .in_ready  (in_ready14),
    .in_data   (in_data14),
    .rk_idx    (rk_idx14),
    .rk_data   (rk_data14),
    .out_valid (out_valid14),
    .out_ready (out_ready14),
    .out_data  (out_data14),
    .busy      (busy14)
  );

  function automatic logic [7:0] tb_xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = tb_xt(a);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] b);
    return {b[6:0], b[7]};
  endfunction

  // Forward S-box from first principles: multiplicative inverse then affine map.
  task automatic build_sbox();
    logic [7:0] inv, s, r;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (tb_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv;
      r = inv;
      for (int k = 0; k < 4; k++) begin
        r = rotl1(r);
        s = s ^ r;
      end
      sbox_t[x] = s ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
  endfunction

  task automatic expand(input logic [255:0] key, input int nk, input int nr);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i - 1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = tb_xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i - nk] ^ t;
    end
  endtask

  task automatic load_ks10(input logic [255:0] key);
    expand(key, 4, 10);
    for (int j = 0; j < 16; j++) ks10[j] = (j <= 10) ? {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]} : '0;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One block through the NR=10 core: hold = cycles out_ready stays low after
  // out_valid rises, junk = pulse in_valid with garbage mid-block.
  task automatic run10(input string tag, input logic [127:0] ct, input logic [127:0] pt,
                       input int hold, input bit junk);
    int n;
    bit seq_ok;
    bit stable_ok;
    check({tag, ":in_ready_idle"}, 128'(in_ready), 128'(1));
    check({tag, ":rk_idx_idle"}, 128'(rk_idx), 128'(10));
    in_data   = ct;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    tick();
    in_valid = 1'b0;
    in_data  = '0;
    n = 0;
    seq_ok = 1'b1;
    while (out_valid !== 1'b1 && n < 40) begin
      if (n > 9 || rk_idx !== 4'(9 - n)) seq_ok = 1'b0;
      if (in_ready !== 1'b0 || busy !== 1'b1) seq_ok = 1'b0;
      if (junk) begin
        in_valid = (n == 3 || n == 6);
        in_data  = {$urandom, $urandom, $urandom, $urandom};
      end
      tick();
      n++;
    end
    in_valid = 1'b0;
    check({tag, ":latency"}, 128'(n), 128'(10));
    check({tag, ":rk_seq_busy"}, 128'(seq_ok), 128'(1));
    check({tag, ":out_data"}, out_data, pt);
    check({tag, ":busy_done"}, 128'(busy), 128'(1));
    stable_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (out_valid !== 1'b1 || out_data !== pt || in_ready !== 1'b0) stable_ok = 1'b0;
    end
    if (hold > 0) check({tag, ":held_stable"}, 128'(stable_ok), 128'(1));
    out_ready = 1'b1;
    tick();
    check({tag, ":post_valid"}, 128'(out_valid), 128'(0));
    check({tag, ":post_in_ready"}, 128'(in_ready), 128'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    build_sbox();
    load_ks10(K1);
    expand(K3, 8, 14);
    for (int j = 0; j < 16; j++) ks14[j] = (j <= 14) ? {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]} : '0;

    check("model_rk10", ks10[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

    // Reset state
    repeat (2) tick();
    check("rst:in_ready", 128'(in_ready), 128'(0));
    check("rst:out_valid", 128'(out_valid), 128'(0));
    check("rst:out_data", out_data, 128'h0);
    check("rst:busy", 128'(busy), 128'(0));
    check("rst:rk_idx", 128'(rk_idx), 128'(10));
    rst = 1'b0;
    #1;
    check("rst_rel:in_ready", 128'(in_ready), 128'(1));

    // FIPS-197 C.1
    run10("c1", CT1, PT1, 0, 1'b0);

    // Backpressure: out_ready low for 7 cycles
    run10("bp", CT1, PT1, 7, 1'b0);

    // in_valid with junk while busy is ignored
    run10("junk", CT1, PT1, 0, 1'b1);

    // Reset while in ROUND at rnd=5
    in_data  = CT1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (rk_idx !== 4'd5 && n < 20) begin
      tick();
      n++;
    end
    check("mid:reach_rnd5", 128'(n), 128'(4));
    rst = 1'b1;
    #1;
    check("mid:out_valid", 128'(out_valid), 128'(0));
    check("mid:out_data", out_data, 128'h0);
    check("mid:busy", 128'(busy), 128'(0));
    tick();
    rst = 1'b0;
    #1;
    check("mid:in_ready", 128'(in_ready), 128'(1));
    check("mid:rk_idx", 128'(rk_idx), 128'(10));
    run10("after_rst", CT1, PT1, 0, 1'b0);

    // FIPS-197 Appendix B
    load_ks10(K2);
    #1;
    run10("b", CT2, PT2, 0, 1'b0);

    // NR=14, FIPS-197 C.3
    check("c3:in_ready", 128'(in_ready14), 128'(1));
    check("c3:rk_idx_idle", 128'(rk_idx14), 128'(14));
    in_data14  = CT3;
    in_valid14 = 1'b1;
    tick();
    in_valid14 = 1'b0;
    n = 0;
    while (out_valid14 !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    check("c3:latency", 128'(n), 128'(14));
    check("c3:out_data", out_data14, PT1);
    check("c3:busy", 128'(busy14), 128'(1));
    tick();
    check("c3:post_valid", 128'(out_valid14), 128'(0));
    check("c3:post_in_ready", 128'(in_ready14), 128'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
